apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB requester that sits directly upstream of the PWM slave.
- Converts a simple valid/ready command stream (from a CPU shim or sequencer) into compliant two-phase APB transfers: SETUP, then ACCESS with PREADY wait states.
- Returns one response per command, carrying read data and an error flag.
- Detects misaligned addresses and slave hangs, so a stuck slave cannot lock the command stream.

Parameters:
- DATA_WIDTH, 32, width of PADDR, PWDATA, PRDATA, cmd_addr, cmd_wdata, rsp_rdata.
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  DATA_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  PSERR, timeout, or misalignment.
- PADDR  out  DATA_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PREADY  in  1  slave ready.
- PSERR  in  1  slave error, sampled with PREADY.
- PRDATA  in  DATA_WIDTH  slave read data.

Behaviour:
- Reset, asynchronous, any state:
  - State goes to IDLE.
  - All outputs go to 0 except cmd_ready=1.
  - Wait counter is cleared.
  - An in-flight transfer is dropped with no response.
- States: IDLE, SETUP, ACCESS, RESP.
- cmd_ready=1 only in IDLE. A command is accepted on the rising edge where cmd_valid&&cmd_ready.
- Accept edge:
  - cmd_write, cmd_addr and cmd_wdata are latched into PWRITE, PADDR and PWDATA.
  - If cmd_addr[1:0]!=0, go to RESP with err=1; no APB transfer occurs.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL=1, PENABLE=0.
  - Next state is ACCESS; wait counter cleared.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR, PWRITE and PWDATA are held stable from SETUP until the transfer ends.
  - On an edge with PREADY=1: capture err=PSERR; capture rdata=PRDATA if read and PSERR=0, else 0; go to RESP.
  - On an edge with PREADY=0: counter increments.
  - If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 while PREADY=0: go to RESP with err=1, rdata=0.
  - The counter saturates and never wraps.
- RESP (exactly 1 cycle):
  - PSEL=0, PENABLE=0.
  - rsp_valid=1; rsp_rdata and rsp_err driven from captured values.
  - Next state IDLE.
  - rsp_rdata and rsp_err hold their values until the next response; rsp_valid is 0 outside RESP.
- PADDR, PWRITE and PWDATA keep their last value when idle. PENABLE is never 1 while PSEL=0.
- Latency:
  - Zero-wait transfer: accept edge k; SETUP cycle k+1; ACCESS cycle k+2; rsp_valid high in cycle k+3; cmd_ready high again in k+4.
  - Minimum spacing between accepted commands is 4 cycles.
  - Each PREADY-low cycle adds 1 cycle.
- No response back-pressure: consumers must take rsp_valid in its cycle.
- Commands presented while cmd_ready=0 are not consumed; the source must hold them.
- PREADY or PSERR values outside ACCESS are ignored.

Test Plan:
- Zero-wait write: cmd addr 0x0, wdata 30, write.
  - Required: PSEL=1/PENABLE=0 for one cycle, then PSEL=1/PENABLE=1 with PADDR=0x0, PWDATA=30.
  - Required: rsp_valid at accept+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr 0x4; PREADY low 3 ACCESS cycles, then high with PRDATA=10.
  - Required: ACCESS lasts 4 cycles, PADDR stable throughout.
  - Required: rsp_rdata=10, rsp_err=0 at accept+6.
- Slave error: read addr 0xc; PREADY=1 with PSERR=1 on the first ACCESS cycle.
  - Required: rsp_err=1, rsp_rdata=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0.
  - Required: ACCESS ends after 4 cycles, PSEL drops, rsp_err=1.
  - Required: next command accepted normally.
- Misaligned: write addr 0x6.
  - Required: PSEL never asserts; rsp_valid at accept+1 with rsp_err=1.
- Reset mid-ACCESS: drop PRESETn while PSEL=PENABLE=1.
  - Required: PSEL, PENABLE and rsp_valid go to 0 immediately (asynchronously); cmd_ready=1; no response is issued after release.
  - Then the write sequence 0x0←30, 0x4←10, 0xc←20, 0x8←1 completes with four error-free responses.

Source files
------------

// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   Converts a valid/ready command stream into two-phase APB transfers
//   (SETUP, then ACCESS with PREADY wait states). It returns exactly one
//   response per accepted command. Misaligned addresses are rejected
//   without touching the bus. A slave that holds PREADY low for too long
//   is abandoned after TIMEOUT_CYCLES ACCESS cycles.
//
// Ports
//   PCLK, PRESETn                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (ready only when idle)
//   cmd_write, cmd_addr, cmd_wdata   command payload
//   rsp_valid                        one-cycle response strobe (no back-pressure)
//   rsp_rdata, rsp_err               response payload, held until next response
//   PADDR, PSEL, PENABLE, PWRITE,
//   PWDATA                           APB requester outputs
//   PREADY, PSERR, PRDATA            APB completer inputs (used only in ACCESS)
module apb_cmd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  // Wide enough to hold TIMEOUT_CYCLES; one bit when the timeout is off.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        wait_cnt, wait_cnt_nxt;
  logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;
  logic                    rsp_err_nxt;
  logic                    load_cmd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Bus strobes and handshakes decode straight from the state register, so
  // the asynchronous reset clears them immediately.
  assign cmd_ready = (state == IDLE);
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    load_cmd      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load_cmd = 1'b1;
          if (cmd_addr[1:0] != 2'b00) begin
            state_nxt     = RESP;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
          end else begin
            state_nxt = SETUP;
          end
        end
      end
      SETUP: begin
        state_nxt    = ACCESS;
        wait_cnt_nxt = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          state_nxt     = RESP;
          rsp_err_nxt   = PSERR;
          rsp_rdata_nxt = (!PWRITE && !PSERR) ? PRDATA : '0;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST)) begin
          state_nxt     = RESP;
          rsp_err_nxt   = 1'b1;
          rsp_rdata_nxt = '0;
        end else begin
          wait_cnt_nxt = sat_inc(wait_cnt);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      // Address/data stay put from SETUP through the end of ACCESS and
      // afterwards until the next command is taken.
      if (load_cmd) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [DW-1:0] cmd_addr = '0, cmd_wdata = '0;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [DW-1:0] PADDR, PWDATA;
  logic          PSEL, PENABLE, PWRITE;
  logic          PREADY = 1'b0, PSERR = 1'b0;
  logic [DW-1:0] PRDATA = '0;

  apb_cmd_master #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PSERR(PSERR), .PRDATA(PRDATA)
  );

  initial forever #5 PCLK = ~PCLK;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            acc;
    int            lat;
  } rsp_t;
  typedef struct {
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
  } apb_t;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int            slv_waits = 0;
  logic          slv_err = 1'b0;
  logic [DW-1:0] slv_rdata = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none (t=%0t)", name, $time);
  endtask

  initial forever @(posedge PCLK) cyc++;

  // APB completer: PREADY goes high on ACCESS cycle number slv_waits.
  initial begin
    int acc_cnt = 0;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        if (acc_cnt == slv_waits) begin
          PREADY = 1'b1; PSERR = slv_err; PRDATA = slv_rdata;
        end else begin
          PREADY = 1'b0; PSERR = 1'b0; PRDATA = 32'hbad0bad0;
        end
        acc_cnt++;
      end else begin
        acc_cnt = 0; PREADY = 1'b0; PSERR = 1'b0; PRDATA = 32'hbad0bad0;
      end
    end
  end

  // Monitor: protocol checks and response scoreboard.
  initial begin
    apb_t cur;
    rsp_t e;
    bit   prev_setup = 1'b0;
    cur = '{addr: '0, wdata: '0, wr: 1'b0};
    forever begin
      @(negedge PCLK);
      if (PENABLE) chk("psel_with_penable", {31'b0, PSEL}, 32'd1);
      if (prev_setup) chk("access_after_setup", {30'b0, PSEL, PENABLE}, 32'd3);
      if (PSEL && !PENABLE) begin
        if (apb_q.size() == 0) fail_now("unexpected_setup");
        else begin
          cur = apb_q.pop_front();
          chk("setup_paddr", PADDR, cur.addr);
          chk("setup_pwrite", {31'b0, PWRITE}, {31'b0, cur.wr});
          chk("setup_pwdata", PWDATA, cur.wdata);
        end
      end
      if (PSEL && PENABLE) begin
        chk("access_paddr", PADDR, cur.addr);
        chk("access_pwrite", {31'b0, PWRITE}, {31'b0, cur.wr});
        chk("access_pwdata", PWDATA, cur.wdata);
      end
      prev_setup = PSEL && !PENABLE;
      if (rsp_valid) begin
        if (rsp_q.size() == 0) fail_now("unexpected_rsp");
        else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                      input int waits, input logic serr, input logic [DW-1:0] prdata,
                      input logic [DW-1:0] exp_rdata, input logic exp_err, input int exp_lat,
                      input bit expect_rsp);
    int guard = 0;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    while (!cmd_ready && guard < 200) begin
      @(negedge PCLK);
      guard++;
    end
    if (!cmd_ready) fail_now("cmd_ready_timeout");
    slv_waits = waits; slv_err = serr; slv_rdata = prdata;
    if (expect_rsp)
      rsp_q.push_back('{rdata: exp_rdata, err: exp_err, acc: cyc + 1, lat: exp_lat});
    if (addr[1:0] == 2'b00) apb_q.push_back('{addr: addr, wdata: wdata, wr: wr});
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
  endtask

  initial begin
    int guard;
    repeat (2) @(negedge PCLK);
    chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("reset_psel", {31'b0, PSEL}, 32'd0);
    chk("reset_penable", {31'b0, PENABLE}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_paddr", PADDR, 32'd0);
    chk("reset_pwdata", PWDATA, 32'd0);
    PRESETn = 1'b1;

    // wr addr wdata waits serr prdata | exp_rdata exp_err lat
    send(1'b1, 32'h0,  32'd30, 0,   1'b0, 32'h0,    32'h0,  1'b0, 3, 1'b1);
    send(1'b0, 32'h4,  32'h0,  3,   1'b0, 32'd10,   32'd10, 1'b0, 6, 1'b1);
    send(1'b0, 32'hc,  32'h0,  0,   1'b1, 32'hdead, 32'h0,  1'b1, 3, 1'b1);
    send(1'b0, 32'h10, 32'h0,  100, 1'b0, 32'h0,    32'h0,  1'b1, 6, 1'b1);
    send(1'b0, 32'h8,  32'h0,  0,   1'b0, 32'h55,   32'h55, 1'b0, 3, 1'b1);
    send(1'b1, 32'h6,  32'h77, 0,   1'b0, 32'h0,    32'h0,  1'b1, 1, 1'b1);
    send(1'b1, 32'h8,  32'h1234, 1, 1'b0, 32'hffff, 32'h0,  1'b0, 4, 1'b1);

    // Reset while the slave is stalling in ACCESS; no response may follow.
    send(1'b0, 32'h4, 32'h0, 100, 1'b0, 32'h99, 32'h0, 1'b0, 0, 1'b0);
    guard = 0;
    while (!(PSEL && PENABLE) && guard < 20) begin
      @(negedge PCLK);
      guard++;
    end
    if (!(PSEL && PENABLE)) fail_now("reach_access_timeout");
    #2;
    PRESETn = 1'b0;
    #1;
    chk("async_psel", {31'b0, PSEL}, 32'd0);
    chk("async_penable", {31'b0, PENABLE}, 32'd0);
    chk("async_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("async_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (6) @(negedge PCLK);

    send(1'b1, 32'h0, 32'd30, 0, 1'b0, 32'h0, 32'h0, 1'b0, 3, 1'b1);
    send(1'b1, 32'h4, 32'd10, 0, 1'b0, 32'h0, 32'h0, 1'b0, 3, 1'b1);
    send(1'b1, 32'hc, 32'd20, 0, 1'b0, 32'h0, 32'h0, 1'b0, 3, 1'b1);
    send(1'b1, 32'h8, 32'd1,  0, 1'b0, 32'h0, 32'h0, 1'b0, 3, 1'b1);

    guard = 0;
    while (rsp_q.size() != 0 && guard < 100) begin
      @(negedge PCLK);
      guard++;
    end
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    chk("apb_queue_drained", 32'(apb_q.size()), 32'd0);
    repeat (3) @(negedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
